// File: rtl/ff_bank_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ff_bank_pkg
// Description : Shared constants and round-robin pick helper for the
//               register-bank write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ff_bank_pkg;

    localparam int NREQ_DEF = 4;
    localparam int NREG_DEF = 8;
    localparam int DW_DEF   = 8;

    // The pick helper is sized for the largest supported requester count;
    // callers zero-extend their eligibility vector into it.
    localparam int MAX_NREQ = 8;
    localparam int PTR_W    = 3;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First eligible index at or after ptr, wrapping at nreq.
    // The offsets are walked from farthest to nearest so the nearest
    // eligible candidate is the last one written and therefore wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] eligible,
                                         input logic [PTR_W-1:0]    ptr,
                                         input int                  nreq);
        rr_pick_t r;
        int       cand;
        r = '0;
        for (int off = MAX_NREQ - 1; off >= 0; off--) begin
            if (off < nreq) begin
                cand = int'(ptr) + off;
                if (cand >= nreq) begin
                    cand = cand - nreq;
                end
                if (eligible[cand]) begin
                    r.valid = 1'b1;
                    r.idx   = cand[PTR_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ff_bank_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ff_bank_wr_arbiter_if
// Description : Write-request bus between the control masters and the
//               register-bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ff_bank_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               busy;

    modport master (output req, req_addr, req_data, input gnt, busy);
    modport slave  (input req, req_addr, req_data, output gnt, busy);
endinterface
`default_nettype wire

// File: rtl/ff_bank_wr_arbiter_regs.sv
`default_nettype none
// ============================================================================
// Module      : ff_bank_regs
// Description : NREG x DW enable-gated register bank with shared write data,
//               synchronous clear and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_bank_regs #(
    parameter int NREG = 8,
    parameter int DW   = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               clr,
    input  wire logic [NREG-1:0]    wr_en,
    input  wire logic [DW-1:0]      wr_data,
    output logic      [NREG*DW-1:0] bank_q
);

    for (genvar k = 0; k < NREG; k++) begin : g_reg
        logic [DW-1:0] reg_d;
        logic [DW-1:0] reg_q;

        // Clear beats write; otherwise load only when this register is enabled.
        always_comb begin
            reg_d = reg_q;
            if (clr) begin
                reg_d = '0;
            end else if (wr_en[k]) begin
                reg_d = wr_data;
            end
        end

        // Register storage, cleared immediately on reset.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign bank_q[k*DW +: DW] = reg_q;
    end

endmodule
`default_nettype wire

// File: rtl/ff_bank_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ff_bank_wr_arbiter
// Description : Round-robin arbiter sharing one register bank among NREQ
//               writers; one write per clock, one-cycle grant pulse back.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_bank_wr_arbiter
    import ff_bank_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               clr,
    ff_bank_wr_arbiter_if.slave     wr,
    output logic      [NREG*DW-1:0] bank_q
);

    localparam int AW = $clog2(NREG);

    logic [NREQ-1:0]     gnt_d, gnt_q;
    logic [PTR_W-1:0]    ptr_d, ptr_q;
    logic [NREQ-1:0]     eligible;
    logic [MAX_NREQ-1:0] elig_ext;
    rr_pick_t            pick;
    logic                do_write;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [NREG-1:0]     wr_en;

    // The requester granted this cycle is masked so it has one cycle to drop req.
    always_comb begin
        eligible = wr.req & ~gnt_q;
        elig_ext = '0;
        elig_ext[NREQ-1:0] = eligible;
        pick     = rr_pick(elig_ext, ptr_q, NREQ);
        do_write = pick.valid & ~clr;
    end

    // Steer the winner's address and data onto the shared write path.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(pick.idx) == i) begin
                wr_addr = wr.req_addr[i*AW +: AW];
                wr_data = wr.req_data[i*DW +: DW];
            end
        end
    end

    // One-hot register enable; zero when clr or nothing is eligible.
    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            wr_en[k] = do_write && (wr_addr == AW'(k));
        end
    end

    // Next grant and pointer; clr suppresses the write but leaves ptr alone.
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            gnt_d[i] = do_write && (int'(pick.idx) == i);
        end
        if (do_write) begin
            if (int'(pick.idx) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick.idx + PTR_W'(1);
            end
        end
    end

    // Grant and pointer state, cleared immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign wr.gnt  = gnt_q;
    assign wr.busy = |eligible;

    ff_bank_regs #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regs (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .bank_q  (bank_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_ff_bank_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ff_bank_wr_arbiter
// Description : Scoreboard bench for the register-bank write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_bank_wr_arbiter;

    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int DW   = 8;
    localparam int AW   = $clog2(NREG);
    localparam int BW   = NREG * DW;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          clr   = 1'b0;
    logic [BW-1:0] bank_q;

    ff_bank_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wr();

    ff_bank_wr_arbiter #(.NREQ(NREQ), .NREG(NREG), .DW(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .wr     (wr),
        .bank_q (bank_q)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-requester address/data, held by the stimulus while a request is pending.
    logic [AW-1:0] a_addr [NREQ];
    logic [DW-1:0] a_data [NREQ];

    // Reference model: bank contents, visible grant and rotation pointer.
    logic [DW-1:0]   m_bank [NREG];
    logic [NREQ-1:0] m_gnt;
    int              m_ptr;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [BW-1:0]   bank;
        logic            busy;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] model_bank();
        logic [BW-1:0] b;
        for (int k = 0; k < NREG; k++) b[k*DW +: DW] = m_bank[k];
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_bank[k] = '0;
        m_gnt = '0;
        m_ptr = 0;
    endtask

    // What the next rising edge does under the arbitration rules.
    task automatic model_edge(input logic rs, input logic cl, input logic [NREQ-1:0] r);
        logic [NREQ-1:0] elig;
        int              win;
        if (rs) begin
            model_reset();
        end else if (cl) begin
            for (int k = 0; k < NREG; k++) m_bank[k] = '0;
            m_gnt = '0;
        end else begin
            elig = r & ~m_gnt;
            win  = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && elig[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
            if (win >= 0) begin
                m_bank[a_addr[win]] = a_data[win];
                m_gnt = '0;
                m_gnt[win] = 1'b1;
                m_ptr = (win + 1) % NREQ;
            end else begin
                m_gnt = '0;
            end
        end
    endtask

    // One clock of stimulus: drive inputs just after the edge, queue what the
    // DUT must show during this cycle, then advance the model past the next edge.
    task automatic step(input logic rs, input logic cl, input logic [NREQ-1:0] r);
        exp_t e;
        @(posedge clk);
        #1;
        if (rs && !reset) check("gnt_before_reset", BW'(wr.gnt), BW'(m_gnt));
        reset = rs;
        clr   = cl;
        wr.req = r;
        for (int i = 0; i < NREQ; i++) begin
            wr.req_addr[i*AW +: AW] = a_addr[i];
            wr.req_data[i*DW +: DW] = a_data[i];
        end
        if (rs) model_reset();
        e.gnt  = m_gnt;
        e.bank = model_bank();
        e.busy = |(r & ~m_gnt);
        exp_q.push_back(e);
        model_edge(rs, cl, r);
    endtask

    // Monitor: compare each cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt",    BW'(wr.gnt),  BW'(e.gnt));
            check("bank_q", bank_q,       e.bank);
            check("busy",   BW'(wr.busy), BW'(e.busy));
        end
    end

    initial begin
        logic [NREQ-1:0] cur_req;
        int              guard;

        wr.req      = '0;
        wr.req_addr = '0;
        wr.req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_addr[i] = AW'(i);
            a_data[i] = DW'(8'h10 + i);
        end
        model_reset();

        // Reset with all requesting, then rotation from requester 0.
        repeat (3) step(1'b1, 1'b0, 4'b1111);
        repeat (9) step(1'b0, 1'b0, 4'b1111);
        repeat (2) step(1'b0, 1'b0, 4'b0000);

        // Single request to register 3 on a cleared bank.
        step(1'b0, 1'b1, 4'b0000);
        a_addr[2] = 3'd3;
        a_data[2] = 8'hA5;
        step(1'b0, 1'b0, 4'b0100);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);

        // Two writers to address 5 starting from ptr=0.
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);
        a_addr[1] = 3'd5; a_data[1] = 8'h11;
        a_addr[2] = 3'd5; a_data[2] = 8'h22;
        step(1'b0, 1'b0, 4'b0110);
        step(1'b0, 1'b0, 4'b0100);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);
        if (m_bank[5] !== 8'h22) check("model_reg5", BW'(m_bank[5]), BW'(8'h22));

        // clr wins over a pending write, which lands once clr drops.
        a_addr[0] = 3'd0; a_data[0] = 8'hFF;
        step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b0, 4'b0001);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);

        // Reset asserted while requester 1 holds the grant.
        for (int i = 0; i < NREQ; i++) begin
            a_addr[i] = AW'(NREQ + i);
            a_data[i] = DW'(8'hC0 + i);
        end
        guard = 0;
        do begin
            step(1'b0, 1'b0, 4'b1111);
            guard++;
        end while (m_gnt != 4'b0010 && guard < 8);
        if (guard >= 8) check("reach_gnt_0010", BW'(m_gnt), BW'(4'b0010));
        step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);
        repeat (6) step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b0, 4'b0000);

        // Randomized traffic: requests held until granted, occasional clr.
        cur_req = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (cur_req[i]) begin
                    if (m_gnt[i]) begin
                        if ($urandom_range(3) != 0) begin
                            cur_req[i] = 1'b0;
                        end else begin
                            a_data[i] = DW'($urandom);
                        end
                    end
                end else if ($urandom_range(2) == 0) begin
                    cur_req[i] = 1'b1;
                    a_addr[i]  = AW'($urandom_range(NREG - 1));
                    a_data[i]  = DW'($urandom);
                end
            end
            step(1'b0, ($urandom_range(15) == 0), cur_req);
        end
        step(1'b0, 1'b0, 4'b0000);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) check("queue_drained", BW'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
